basket_controller: RTL and testbench

- Sequences the sale terminal's basket: adds the cursor-selected product, removes basket entries, keeps a running total and runs the checkout handshake.
- Sits between the debounced buttons/state machine and the product-navigation block.
- Gates navigation via Nav_enable and supplies BasketProductNum and per-entry display data.
- Reads unit prices from the product price ROM through Price_addr/Price_in.

---
 rtl/sale_terminal_pkg.sv | 26 ++
 rtl/basket_controller_if.sv | 39 +++
 rtl/basket_store.sv | 51 +++++
 rtl/basket_controller.sv | 207 ++++++++++++++++++++
 tb/tb_basket_controller.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sale_terminal_pkg.sv
// Shared types and defaults for the sale terminal basket logic.
package sale_terminal_pkg;

  localparam int unsigned CATALOGUE_SIZE = 12;

  localparam int unsigned DEF_MAX_ITEMS = 8;
  localparam int unsigned DEF_MAX_QTY   = 9;
  localparam int unsigned DEF_PRICE_W   = 8;
  localparam int unsigned DEF_TOTAL_W   = 12;

  typedef enum logic [2:0] {
    S_BROWSE   = 3'd0,
    S_SEARCH   = 3'd1,
    S_ADDPRICE = 3'd2,
    S_SUBPRICE = 3'd3,
    S_SHIFT    = 3'd4,
    S_CHECKOUT = 3'd5,
    S_CLEAR    = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] qty;
  } entry_t;

endpackage

// File: rtl/basket_controller_if.sv
// Button, navigation, price ROM and status signals of the basket controller.
interface basket_controller_if #(
  parameter int unsigned PRICE_W = sale_terminal_pkg::DEF_PRICE_W,
  parameter int unsigned TOTAL_W = sale_terminal_pkg::DEF_TOTAL_W
);
  logic               CleanSW2;
  logic [3:0]         ProductID;
  logic               Btn_select;
  logic               Btn_remove;
  logic               Btn_checkout;
  logic               Btn_cancel;
  logic               Pay_ok;
  logic [PRICE_W-1:0] Price_in;
  logic [3:0]         Price_addr;
  logic               Nav_enable;
  logic [3:0]         BasketProductNum;
  logic [3:0]         Disp_id;
  logic [3:0]         Disp_qty;
  logic [TOTAL_W-1:0] Total;
  logic               Busy;
  logic               Err;
  logic               CheckoutDone;

  // Terminal side: buttons, cursor and price ROM data.
  modport master (
    output CleanSW2, ProductID, Btn_select, Btn_remove, Btn_checkout,
           Btn_cancel, Pay_ok, Price_in,
    input  Price_addr, Nav_enable, BasketProductNum, Disp_id, Disp_qty,
           Total, Busy, Err, CheckoutDone
  );

  // Controller side.
  modport slave (
    input  CleanSW2, ProductID, Btn_select, Btn_remove, Btn_checkout,
           Btn_cancel, Pay_ok, Price_in,
    output Price_addr, Nav_enable, BasketProductNum, Disp_id, Disp_qty,
           Total, Busy, Err, CheckoutDone
  );
endinterface

// File: rtl/basket_store.sv
// Basket entry register file: indexed write, single-step shift-down,
// bulk clear and two combinational read ports.
module basket_store
  import sale_terminal_pkg::*;
#(
  parameter int unsigned MAX_ITEMS = DEF_MAX_ITEMS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  entry_t     wr_data,
  input  logic       shift_en,
  input  logic [3:0] shift_idx,
  input  logic       clear,
  input  logic [3:0] rd_a_idx,
  output entry_t     rd_a_data,
  input  logic [3:0] rd_b_idx,
  output entry_t     rd_b_data
);

  entry_t entries [MAX_ITEMS];
  entry_t shift_src;

  // Read ports; indexes beyond capacity read as an empty entry.
  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    shift_src = '0;
    for (int unsigned j = 0; j < MAX_ITEMS; j++) begin
      if (4'(j) == rd_a_idx) rd_a_data = entries[j];
      if (4'(j) == rd_b_idx) rd_b_data = entries[j];
      if (4'(j) == shift_idx + 4'd1) shift_src = entries[j];
    end
  end

  // Entry storage update: clear wins, then shift, then write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_ITEMS; i++) entries[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < MAX_ITEMS; i++) entries[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < MAX_ITEMS; i++) begin
        if (shift_en && 4'(i) == shift_idx) entries[i] <= shift_src;
        else if (wr_en && 4'(i) == wr_idx) entries[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/basket_controller.sv
// Basket sequencer: add/remove entries, running total and checkout handshake.
module basket_controller
  import sale_terminal_pkg::*;
#(
  parameter int unsigned MAX_ITEMS = DEF_MAX_ITEMS,
  parameter int unsigned MAX_QTY   = DEF_MAX_QTY,
  parameter int unsigned PRICE_W   = DEF_PRICE_W,
  parameter int unsigned TOTAL_W   = DEF_TOTAL_W
) (
  input logic CLOCK,
  input logic RESET,
  basket_controller_if.slave bus
);

  state_t             state;
  logic [3:0]         count;
  logic [3:0]         idx;
  logic [3:0]         key;
  logic [TOTAL_W-1:0] total;
  logic               err;
  logic               done;

  logic               wr_en;
  logic [3:0]         wr_idx;
  entry_t             wr_data;
  logic               shift_en;
  logic               clear;
  entry_t             cur;
  entry_t             view;

  logic [PRICE_W-1:0] price;
  logic [TOTAL_W-1:0] price_ext;
  logic [TOTAL_W:0]   sum_ext;
  logic               show;

  basket_store #(.MAX_ITEMS(MAX_ITEMS)) u_store (
    .clk       (CLOCK),
    .rst       (RESET),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .shift_en  (shift_en),
    .shift_idx (idx),
    .clear     (clear),
    .rd_a_idx  (idx),
    .rd_a_data (cur),
    .rd_b_idx  (bus.ProductID),
    .rd_b_data (view)
  );

  // Price arithmetic on the zero-extended ROM value.
  always_comb begin
    price     = bus.Price_in;
    price_ext = TOTAL_W'(price);
    sum_ext   = {1'b0, total} + {1'b0, price_ext};
  end

  // Entry store commands, derived from the same conditions the FSM uses.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = idx;
    wr_data  = '0;
    shift_en = 1'b0;
    clear    = 1'b0;
    case (state)
      S_SEARCH: begin
        if (idx == count) begin
          if (count != 4'(MAX_ITEMS)) begin
            wr_en       = 1'b1;
            wr_idx      = count;
            wr_data.id  = key;
            wr_data.qty = 4'd1;
          end
        end else if (cur.id == key && cur.qty != 4'(MAX_QTY)) begin
          wr_en       = 1'b1;
          wr_data.id  = key;
          wr_data.qty = cur.qty + 4'd1;
        end
      end
      S_SUBPRICE: begin
        if (cur.qty > 4'd1) begin
          wr_en       = 1'b1;
          wr_data.id  = cur.id;
          wr_data.qty = cur.qty - 4'd1;
        end
      end
      S_SHIFT: begin
        if (idx + 4'd1 < count) begin
          shift_en = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = count - 4'd1;
        end
      end
      S_CLEAR: clear = 1'b1;
      default: ;
    endcase
  end

  // Main sequencer with registered Err/CheckoutDone pulses.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_BROWSE;
      count <= '0;
      idx   <= '0;
      key   <= '0;
      total <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_BROWSE: begin
          if (bus.Btn_cancel) begin
            state <= S_CLEAR;
          end else if (bus.Btn_checkout) begin
            if (count == 4'd0) err <= 1'b1;
            else state <= S_CHECKOUT;
          end else if (bus.Btn_remove) begin
            if (bus.CleanSW2) begin
              if (bus.ProductID >= count) begin
                err <= 1'b1;
              end else begin
                idx   <= bus.ProductID;
                key   <= view.id;
                state <= S_SUBPRICE;
              end
            end
          end else if (bus.Btn_select && !bus.CleanSW2) begin
            key   <= bus.ProductID;
            idx   <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (idx == count) begin
            if (count == 4'(MAX_ITEMS)) begin
              err   <= 1'b1;
              state <= S_BROWSE;
            end else begin
              count <= count + 4'd1;
              state <= S_ADDPRICE;
            end
          end else if (cur.id == key) begin
            if (cur.qty == 4'(MAX_QTY)) begin
              err   <= 1'b1;
              state <= S_BROWSE;
            end else begin
              state <= S_ADDPRICE;
            end
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_ADDPRICE: begin
          if (sum_ext[TOTAL_W]) begin
            total <= '1;
            err   <= 1'b1;
          end else begin
            total <= sum_ext[TOTAL_W-1:0];
          end
          state <= S_BROWSE;
        end
        S_SUBPRICE: begin
          total <= (total < price_ext) ? '0 : total - price_ext;
          state <= (cur.qty > 4'd1) ? S_BROWSE : S_SHIFT;
        end
        S_SHIFT: begin
          if (idx + 4'd1 < count) begin
            idx <= idx + 4'd1;
          end else begin
            count <= count - 4'd1;
            state <= S_BROWSE;
          end
        end
        S_CHECKOUT: begin
          if (bus.Pay_ok) begin
            done  <= 1'b1;
            state <= S_CLEAR;
          end else if (bus.Btn_cancel) begin
            state <= S_BROWSE;
          end
        end
        S_CLEAR: begin
          count <= '0;
          idx   <= '0;
          total <= '0;
          state <= S_BROWSE;
        end
        default: state <= S_BROWSE;
      endcase
    end
  end

  assign show                 = bus.CleanSW2 && (bus.ProductID < count);
  assign bus.Disp_id          = show ? view.id  : '0;
  assign bus.Disp_qty         = show ? view.qty : '0;
  assign bus.Price_addr       = key;
  assign bus.Nav_enable       = (state == S_BROWSE);
  assign bus.Busy             = (state != S_BROWSE);
  assign bus.BasketProductNum = count;
  assign bus.Total            = total;
  assign bus.Err              = err;
  assign bus.CheckoutDone     = done;

endmodule

// File: tb/tb_basket_controller.sv
// Directed plus randomized bench for basket_controller with a queue-based basket model.
module tb_basket_controller;

  localparam int MAXI = 8;
  localparam int MAXQ = 9;
  localparam int TMAX = 4095;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  basket_controller_if bus ();

  basket_controller #(
    .MAX_ITEMS (MAXI),
    .MAX_QTY   (MAXQ),
    .PRICE_W   (8),
    .TOTAL_W   (12)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [7:0] rom [16];
  assign bus.Price_in = rom[bus.Price_addr];

  typedef struct {
    int id;
    int qty;
  } ent_t;

  ent_t mq[$];
  int   mtotal = 0;
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;
  int   done_cnt = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.Err === 1'b1) err_cnt++;
    if (bus.CheckoutDone === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit sel, input bit rem, input bit chk, input bit can,
                       input bit pay, input bit sw, input int pid);
    bus.CleanSW2     = sw;
    bus.ProductID    = 4'(pid);
    bus.Btn_select   = sel;
    bus.Btn_remove   = rem;
    bus.Btn_checkout = chk;
    bus.Btn_cancel   = can;
    bus.Pay_ok       = pay;
    step();
    bus.Btn_select   = 1'b0;
    bus.Btn_remove   = 1'b0;
    bus.Btn_checkout = 1'b0;
    bus.Btn_cancel   = 1'b0;
    bus.Pay_ok       = 1'b0;
  endtask

  function automatic int find(input int id);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic finish_op(input string tag, input int exp_low, input int e0, input int d0,
                           input int exp_err, input int exp_done);
    int low;
    low = 0;
    while (bus.Nav_enable !== 1'b1 && low < 64) begin
      low++;
      step();
    end
    check({tag, "_latency"}, low, exp_low);
    check({tag, "_err"}, err_cnt - e0, exp_err);
    check({tag, "_done"}, done_cnt - d0, exp_done);
    check({tag, "_count"}, bus.BasketProductNum, mq.size());
    check({tag, "_total"}, bus.Total, mtotal);
    check({tag, "_busy"}, bus.Busy, 0);
  endtask

  task automatic op_add(input int id);
    int pos, low, e, e0, d0, t;
    e = 0;
    pos = find(id);
    if (pos < 0) pos = mq.size();
    if (pos < mq.size() && mq[pos].qty == MAXQ) begin
      e = 1; low = pos + 1;
    end else if (pos == mq.size() && pos == MAXI) begin
      e = 1; low = pos + 1;
    end else begin
      if (pos < mq.size()) mq[pos].qty++;
      else mq.push_back('{id: id, qty: 1});
      low = pos + 2;
      t = mtotal + int'(rom[id]);
      if (t > TMAX) begin mtotal = TMAX; e = 1; end
      else mtotal = t;
    end
    e0 = err_cnt; d0 = done_cnt;
    pulse(1, 0, 0, 0, 0, 0, id);
    finish_op("add", low, e0, d0, e, 0);
  endtask

  task automatic op_remove(input int i);
    int low, e, e0, d0, t;
    e = 0; low = 0;
    if (i >= mq.size()) begin
      e = 1;
    end else begin
      t = mtotal - int'(rom[mq[i].id]);
      mtotal = (t < 0) ? 0 : t;
      if (mq[i].qty > 1) begin
        mq[i].qty--; low = 1;
      end else begin
        low = 1 + mq.size() - i;
        mq.delete(i);
      end
    end
    e0 = err_cnt; d0 = done_cnt;
    pulse(0, 1, 0, 0, 0, 1, i);
    finish_op("remove", low, e0, d0, e, 0);
  endtask

  task automatic op_checkout(input bit pay, input bit cancel_too, input int wait_n);
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    pulse(0, 0, 1, 0, 0, 0, 0);
    if (mq.size() == 0) begin
      finish_op("checkout_empty", 0, e0, d0, 1, 0);
    end else begin
      check("checkout_nav", bus.Nav_enable, 0);
      for (int k = 0; k < wait_n; k++) step();
      check("checkout_hold", bus.Busy, 1);
      if (pay) begin
        pulse(0, 0, 0, cancel_too, 1, 0, 0);
        check("checkout_done_now", bus.CheckoutDone, 1);
        mq.delete();
        mtotal = 0;
        finish_op("checkout_pay", 1, e0, d0, 0, 1);
      end else begin
        pulse(0, 0, 0, 1, 0, 0, 0);
        finish_op("checkout_cancel", 0, e0, d0, 0, 0);
      end
    end
  endtask

  task automatic op_cancel();
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    pulse(0, 0, 0, 1, 0, 0, 0);
    mq.delete();
    mtotal = 0;
    finish_op("cancel", 1, e0, d0, 0, 0);
  endtask

  task automatic check_display();
    for (int i = 0; i < 10; i++) begin
      bus.CleanSW2  = 1'b1;
      bus.ProductID = 4'(i);
      #1;
      check("disp_id", bus.Disp_id, (i < mq.size()) ? mq[i].id : 0);
      check("disp_qty", bus.Disp_qty, (i < mq.size()) ? mq[i].qty : 0);
    end
    bus.CleanSW2  = 1'b0;
    bus.ProductID = 4'd0;
    #1;
    check("disp_shop_view", {bus.Disp_id, bus.Disp_qty}, 0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nav"}, bus.Nav_enable, 1);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_count"}, bus.BasketProductNum, 0);
    check({tag, "_total"}, bus.Total, 0);
    check({tag, "_err"}, bus.Err, 0);
    check({tag, "_done"}, bus.CheckoutDone, 0);
    check({tag, "_paddr"}, bus.Price_addr, 0);
  endtask

  initial begin
    int e0, d0, r;
    rst = 1'b1;
    bus.CleanSW2 = 1'b0; bus.ProductID = 4'd0;
    bus.Btn_select = 1'b0; bus.Btn_remove = 1'b0; bus.Btn_checkout = 1'b0;
    bus.Btn_cancel = 1'b0; bus.Pay_ok = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(1, 255));
    rom[3] = 8'd25;
    rom[7] = 8'd40;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Add sequence.
    op_add(3); op_add(7); op_add(3);
    check("add_seq_total", bus.Total, 90);
    check_display();

    // Remove and compact.
    op_remove(0);
    check("remove1_total", bus.Total, 65);
    op_remove(0);
    check("remove2_total", bus.Total, 40);
    check_display();

    // Invalid commands.
    op_add(3);
    op_remove(5);
    e0 = err_cnt; d0 = done_cnt;
    pulse(1, 1, 0, 0, 0, 0, 5);
    finish_op("sel_rem_same", 0, e0, d0, 0, 0);
    check_display();

    // Checkout paths.
    op_checkout(1, 0, 2);
    op_checkout(1, 0, 0);
    op_add(7); op_add(3); op_add(7);
    op_checkout(0, 0, 3);
    check("cancel_keeps_nav", bus.Nav_enable, 1);
    check_display();
    op_checkout(1, 1, 1);

    // Capacity limit.
    for (int i = 0; i < 8; i++) op_add(i);
    op_add(8);
    check("full_count", bus.BasketProductNum, 8);
    check_display();
    op_cancel();

    // Quantity limit.
    for (int i = 0; i < 10; i++) op_add(3);
    check_display();

    // Asynchronous reset during S_SHIFT.
    op_cancel();
    op_add(3); op_add(5); op_add(9);
    pulse(0, 1, 0, 0, 0, 1, 0);
    check("shift_busy", bus.Busy, 1);
    step();
    check("shift_busy2", bus.Busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step();
    rst = 1'b0;
    mq.delete();
    mtotal = 0;
    step();
    check_display();

    // Randomized operations against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      op_add($urandom_range(0, 11));
      else if (r < 85) op_remove($urandom_range(0, 9));
      else if (r < 90) op_checkout(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      else if (r < 94) op_checkout(0, 0, $urandom_range(0, 3));
      else if (r < 97) op_cancel();
      else             check_display();
      if (n % 25 == 24) check_display();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
